// File: rtl/fp5_add_arbiter.sv
// Round-robin scheduler sharing one pipelined 5-bit FP adder among NREQ requesters.
// A tag pipe follows each issued operation and routes the adder result back to its owner.
module fp5_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int ADD_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [5*NREQ-1:0]    a_in,
  input  logic [5*NREQ-1:0]    b_in,
  output logic [NREQ-1:0]      gnt,
  output logic [4:0]           add_a,
  output logic [4:0]           add_b,
  input  logic [4:0]           add_sum,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [4:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic [CNT_W-1:0]     in_flight
);

  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NREQ);

  logic [ID_W-1:0]             ptr_q, ptr_d;
  logic [4:0]                  add_a_q, add_a_d, add_b_q, add_b_d;
  logic [ADD_LAT:0]            tag_vld_q;
  logic [ADD_LAT:0][ID_W-1:0]  tag_id_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [NREQ-1:0][ID_W-1:0]   cand;
  logic                        gnt_any;
  logic [ID_W-1:0]             gnt_idx;
  logic                        rsp_hit;
  logic [ID_W-1:0]             rsp_idx;

  // Candidate k is the k-th index visited when searching upward from ptr with wrap.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [ID_W:0] sum_w;
      assign sum_w    = {1'b0, ptr_q} + (ID_W+1)'(gi);
      assign cand[gi] = (sum_w >= NREQ_W) ? ID_W'(sum_w - NREQ_W) : ID_W'(sum_w);
    end
  endgenerate

  // Walk candidates from last to first so the nearest requester to ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        gnt_any = rst_n;
        gnt_idx = cand[k];
      end
    end
  end

  assign gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    ptr_d   = ptr_q;
    add_a_d = '0;
    add_b_d = '0;
    if (gnt_any) begin
      ptr_d   = (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + ID_W'(1);
      add_a_d = a_in[5*gnt_idx +: 5];
      add_b_d = b_in[5*gnt_idx +: 5];
    end
  end

  assign rsp_hit = tag_vld_q[ADD_LAT];
  assign rsp_idx = tag_id_q[ADD_LAT];

  always_comb begin
    cnt_d = cnt_q;
    if (gnt_any && !rsp_hit)
      cnt_d = cnt_q + CNT_W'(1);
    else if (!gnt_any && rsp_hit)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      cnt_q        <= '0;
      tag_vld_q[0] <= 1'b0;
      tag_id_q[0]  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      cnt_q        <= cnt_d;
      tag_vld_q[0] <= gnt_any;
      tag_id_q[0]  <= gnt_idx;
    end
  end

  // The last tag stage lines up with add_sum for the operation it describes.
  generate
    for (genvar gi = 1; gi <= ADD_LAT; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_vld_q[gi] <= 1'b0;
          tag_id_q[gi]  <= '0;
        end else begin
          tag_vld_q[gi] <= tag_vld_q[gi-1];
          tag_id_q[gi]  <= tag_id_q[gi-1];
        end
      end
    end
  endgenerate

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign in_flight = cnt_q;
  assign rsp_valid = rsp_hit ? (NREQ'(1) << rsp_idx) : '0;
  assign rsp_id    = rsp_hit ? rsp_idx : '0;
  assign rsp_data  = rsp_hit ? add_sum : '0;

endmodule

// File: tb/tb_fp5_add_arbiter.sv
// Bench for fp5_add_arbiter: directed scenarios then random traffic, checked
// against a cycle-indexed schedule of expected grants and responses.
module tb_fp5_add_arbiter;
  localparam int NREQ = 4, ID_W = 2, ADD_LAT = 4, CNT_W = 3;
  localparam int MAXC = 2048;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [5*NREQ-1:0] a_in, b_in;
  logic [NREQ-1:0]   gnt;
  logic [4:0]        add_a, add_b, add_sum;
  logic [NREQ-1:0]   rsp_valid;
  logic [4:0]        rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic [CNT_W-1:0]  in_flight;

  fp5_add_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .in_flight(in_flight)
  );

  always #5 clk = ~clk;

  // Stand-in adder: ADD_LAT-cycle pipeline with a distinctive combining function.
  function automatic logic [4:0] fadd(input logic [4:0] a, input logic [4:0] b);
    return a + 5'(b * 3) + 5'd1;
  endfunction

  logic [4:0] pa [ADD_LAT];
  logic [4:0] pb [ADD_LAT];
  always @(posedge clk) begin
    pa[0] <= add_a;
    pb[0] <= add_b;
    for (int i = 1; i < ADD_LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  assign add_sum = fadd(pa[ADD_LAT-1], pb[ADD_LAT-1]);

  int total = 0, bad = 0, cyc = 0;
  int m_ptr = 0, m_cnt = 0, max_cnt = 0;
  logic [4:0] m_a = '0, m_b = '0;
  bit         exp_v [MAXC];
  int         exp_id [MAXC];
  logic [4:0] exp_d [MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  // Check this cycle's outputs against the model, then advance model and clock.
  task automatic tick();
    int g, j;
    logic [4:0] oa, ob;
    #3;
    if (!rst_n) begin
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_in_flight", 32'(in_flight), 0);
      chk("rst_add_a", 32'(add_a), 0);
      chk("rst_add_b", 32'(add_b), 0);
      m_ptr = 0; m_cnt = 0; m_a = '0; m_b = '0;
      for (int i = cyc; i < MAXC; i++) exp_v[i] = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (g < 0 && req[j]) g = j;
      end
      chk("gnt", 32'(gnt), (g < 0) ? 0 : (1 << g));
      chk("rsp_valid", 32'(rsp_valid), exp_v[cyc] ? (1 << exp_id[cyc]) : 0);
      chk("rsp_id", 32'(rsp_id), exp_v[cyc] ? exp_id[cyc] : 0);
      chk("rsp_data", 32'(rsp_data), exp_v[cyc] ? 32'(exp_d[cyc]) : 0);
      chk("in_flight", 32'(in_flight), m_cnt);
      chk("add_a", 32'(add_a), 32'(m_a));
      chk("add_b", 32'(add_b), 32'(m_b));
      if (g >= 0) begin
        oa = a_in[5*g +: 5];
        ob = b_in[5*g +: 5];
        exp_v[cyc+1+ADD_LAT]  = 1'b1;
        exp_id[cyc+1+ADD_LAT] = g;
        exp_d[cyc+1+ADD_LAT]  = fadd(oa, ob);
        m_a = oa; m_b = ob;
        m_ptr = (g + 1) % NREQ;
        m_cnt++;
      end else begin
        m_a = '0; m_b = '0;
      end
      if (exp_v[cyc]) m_cnt--;
      if (m_cnt > max_cnt) max_cnt = m_cnt;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; req = 4'hF;
    a_in = 20'h12345; b_in = 20'h6789A;
    @(posedge clk); #1;
    // Reset with all requests high, then first grant goes to requester 0.
    tick(); tick();
    rst_n = 1'b1;
    tick();
    idle(7);

    // Single issue from requester 2.
    req = 4'b0100;
    a_in = '0; b_in = '0;
    a_in[14:10] = 5'b0_011_1;
    b_in[14:10] = 5'b0_010_0;
    tick();
    idle(7);

    // Fairness: all requesting for 8 cycles.
    req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      a_in = 20'($urandom); b_in = 20'($urandom);
      tick();
    end
    idle(6);

    // Wrap: move ptr to 3, then req=1001.
    req = 4'b0100; tick();
    req = 4'b1001; tick(); tick();
    idle(6);

    // Full pipe from requester 1.
    max_cnt = 0;
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      a_in = 20'($urandom); b_in = 20'($urandom);
      tick();
    end
    idle(7);
    chk("full_pipe_peak", 32'(max_cnt), ADD_LAT + 1);

    // Reset with three ops in flight.
    req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      a_in = 20'($urandom); b_in = 20'($urandom);
      tick();
    end
    rst_n = 1'b0; req = '0;
    tick();
    rst_n = 1'b1;
    idle(2);
    req = 4'b1010;
    tick();
    idle(6);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      req  = NREQ'($urandom);
      a_in = 20'($urandom);
      b_in = 20'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
